// File: rtl/e1_truthtable_pkg.sv
// ============================================================================
// Module      : e1_truthtable_pkg
// Description : Shared widths, FSM state encoding and requester id type for
//               the e1 truth-table datapath and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package e1_truthtable_pkg;

  localparam int A_W = 3;
  localparam int B_W = 4;
  localparam int Y_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

`default_nettype wire

// File: rtl/e1_truthtable.sv
// ============================================================================
// Module      : e1_truthtable
// Description : Combinational truth table mapping operands (a, b) to (x, y).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e1_truthtable
  import e1_truthtable_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           x,
  output logic [Y_W-1:0] y
);

  assign x = a[2] & ~b[0];
  assign y = {a[2] & b[3], ~b[2], a[0] & b[0]};

endmodule

`default_nettype wire

// File: rtl/e1_truthtable_arbiter.sv
// ============================================================================
// Module      : e1_truthtable_arbiter
// Description : Two-requester round-robin arbiter sharing one e1_truthtable.
//               Optional grant counters when E1_TT_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e1_truthtable_arbiter
  import e1_truthtable_pkg::*;
#(
  parameter logic FIRST_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic           rsp_x,
  output logic [Y_W-1:0] rsp_y
`ifdef E1_TT_ARB_STATS_EN
  ,
  output logic [7:0]     grant_cnt0,
  output logic [7:0]     grant_cnt1
`endif
);

  state_e         state_q, state_d;
  req_id_t        ptr_q, ptr_d;
  req_id_t        id_q, id_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic           rsp_valid_q, rsp_valid_d;
  req_id_t        rsp_id_q, rsp_id_d;
  logic           rsp_x_q, rsp_x_d;
  logic [Y_W-1:0] rsp_y_q, rsp_y_d;

  logic           tt_x;
  logic [Y_W-1:0] tt_y;
  logic           sel1;
  logic           accept;

  e1_truthtable u_tt (
    .a (a_q),
    .b (b_q),
    .x (tt_x),
    .y (tt_y)
  );

  // Pointer only matters on contention; a lone valid always wins.
  assign sel1   = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign accept = (state_q == ST_IDLE) & (req0_valid | req1_valid) & ~rst;

  assign req0_ready = accept & ~sel1;
  assign req1_ready = accept &  sel1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_x_d     = rsp_x_q;
    rsp_y_d     = rsp_y_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = sel1 ? req1_a : req0_a;
          b_d     = sel1 ? req1_b : req0_b;
          id_d    = sel1;
          ptr_d   = ~sel1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        rsp_x_d     = tt_x;
        rsp_y_d     = tt_y;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= FIRST_PRIO;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_x_q     <= 1'b0;
      rsp_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_x_q     <= rsp_x_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;

`ifdef E1_TT_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Saturating at 255 so a long run never wraps back to a small count.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (req0_ready && (cnt0_q != 8'hFF)) cnt0_d = cnt0_q + 8'd1;
    if (req1_ready && (cnt1_q != 8'hFF)) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_e1_truthtable_arbiter.sv
// ============================================================================
// Module      : tb_e1_truthtable_arbiter
// Description : Directed self-checking bench for e1_truthtable_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e1_truthtable_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_a, req1_a;
  logic [3:0] req0_b, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_x;
  logic [2:0] rsp_y;
`ifdef E1_TT_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  e1_truthtable_arbiter #(.FIRST_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_x      (rsp_x),
    .rsp_y      (rsp_y)
`ifdef E1_TT_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns on a falling edge with reset released.
  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on a falling edge with requests set; returns on the falling edge after acceptance.
  task automatic wait_grant(output logic id);
    #1;
    for (int k = 0; k < 8 && !(req0_ready || req1_ready); k++) begin
      @(negedge clk);
      #1;
    end
    check("grant_timeout", {7'd0, req0_ready | req1_ready}, 8'd1);
    id = req1_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 8 && !rsp_valid; k++) @(negedge clk);
    check("rsp_timeout", {7'd0, rsp_valid}, 8'd1);
  endtask

  logic id;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 3'd7; req0_b = 4'd2;
    req1_valid = 1'b0; req1_a = 3'd0; req1_b = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_valid", {7'd0, rsp_valid}, 8'd0);
    check("rst_id",    {7'd0, rsp_id},    8'd0);
    check("rst_x",     {7'd0, rsp_x},     8'd0);
    check("rst_y",     {5'd0, rsp_y},     8'd0);
    check("rst_ready0", {7'd0, req0_ready}, 8'd0);

    // Single request: a=7, b=2 -> x=1, y=2 two cycles after accept
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("single_ready0", {7'd0, req0_ready}, 8'd1);
    check("single_ready1", {7'd0, req1_ready}, 8'd0);
    wait_grant(id);
    req0_valid = 1'b0;
    check("single_eval_valid", {7'd0, rsp_valid}, 8'd0);
    @(negedge clk);
    check("single_valid", {7'd0, rsp_valid}, 8'd1);
    check("single_id",    {7'd0, rsp_id},    8'd0);
    check("single_x",     {7'd0, rsp_x},     8'd1);
    check("single_y",     {5'd0, rsp_y},     8'd2);
    @(negedge clk);
    check("single_done", {7'd0, rsp_valid}, 8'd0);

    // Contention: req0 (1,1) -> x0 y3 first, then req1 (4,4) -> x1 y0
    do_reset();
    req0_valid = 1'b1; req0_a = 3'd1; req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 3'd4; req1_b = 4'd4;
    wait_grant(id);
    check("cont_grant0", {7'd0, id}, 8'd0);
    req0_valid = 1'b0;
    wait_rsp();
    check("cont_id0", {7'd0, rsp_id}, 8'd0);
    check("cont_x0",  {7'd0, rsp_x},  8'd0);
    check("cont_y0",  {5'd0, rsp_y},  8'd3);
    @(negedge clk);
    wait_grant(id);
    check("cont_grant1", {7'd0, id}, 8'd1);
    req1_valid = 1'b0;
    wait_rsp();
    check("cont_id1", {7'd0, rsp_id}, 8'd1);
    check("cont_x1",  {7'd0, rsp_x},  8'd1);
    check("cont_y1",  {5'd0, rsp_y},  8'd0);
    @(negedge clk);

    // Fairness: both held valid for 6 grants -> 0,1,0,1,0,1
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(id);
      check("fair_grant", {7'd0, id}, 8'(i % 2));
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      wait_rsp();
      check("fair_rsp_id", {7'd0, rsp_id}, 8'(i % 2));
      @(negedge clk);
    end

    // Backpressure: req1 a=6, b=1 -> x0 y2 held for 5 stalled cycles
    do_reset();
    rsp_ready  = 1'b0;
    req1_valid = 1'b1; req1_a = 3'd6; req1_b = 4'd1;
    wait_grant(id);
    check("bp_grant", {7'd0, id}, 8'd1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 3'd2; req0_b = 4'd3;
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid",  {7'd0, rsp_valid},  8'd1);
      check("bp_id",     {7'd0, rsp_id},     8'd1);
      check("bp_x",      {7'd0, rsp_x},      8'd0);
      check("bp_y",      {5'd0, rsp_y},      8'd2);
      check("bp_ready0", {7'd0, req0_ready}, 8'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_ready0", {7'd0, req0_ready}, 8'd0);
    @(negedge clk);
    #1;
    check("bp_after_valid",  {7'd0, rsp_valid},  8'd0);
    check("bp_after_ready0", {7'd0, req0_ready}, 8'd1);
    req0_valid = 1'b0;

    // Reset during EVAL for a=4, b=1: result is discarded
    do_reset();
    req0_valid = 1'b1; req0_a = 3'd4; req0_b = 4'd1;
    wait_grant(id);
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",  {7'd0, rsp_valid},  8'd0);
    check("mid_rst_id",     {7'd0, rsp_id},     8'd0);
    check("mid_rst_x",      {7'd0, rsp_x},      8'd0);
    check("mid_rst_y",      {5'd0, rsp_y},      8'd0);
    check("mid_rst_ready0", {7'd0, req0_ready}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_no_rsp", {7'd0, rsp_valid}, 8'd0);
    end

`ifdef E1_TT_ARB_STATS_EN
    // Stats: 3 grants to req0 then 2 to req1
    do_reset();
    check("stat_rst0", grant_cnt0, 8'd0);
    check("stat_rst1", grant_cnt1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) req0_valid = 1'b1;
      else       req1_valid = 1'b1;
      wait_grant(id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp();
      @(negedge clk);
    end
    check("stat_cnt0", grant_cnt0, 8'd3);
    check("stat_cnt1", grant_cnt1, 8'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
